// File: rtl/ccff_loader_pkg.sv
// Shared state type and serial CRC-8 helper for the configuration-chain loader.
// CCFF_LOADER_CRC_EN adds the CRC_WAIT state.
package ccff_loader_pkg;

  localparam logic [7:0] CCFF_CRC_POLY = 8'h07;
  localparam logic [7:0] CCFF_CRC_INIT = 8'h00;

`ifdef CCFF_LOADER_CRC_EN
  typedef enum logic [2:0] {StIdle, StLoad, StShift, StCrcWait, StDone} ccff_ld_state_t;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StShift, StDone} ccff_ld_state_t;
`endif

  // One MSB-first CRC step: feedback is the outgoing MSB xor the new data bit.
  function automatic logic [7:0] ccff_crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8 register (poly 0x07, init 0x00), one bit per enabled cycle.
// Only instantiated when CCFF_LOADER_CRC_EN is defined.
module ccff_crc8
  import ccff_loader_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CCFF_CRC_INIT;
    end else if (en_i) begin
      crc_d = ccff_crc8_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= CCFF_CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// Streams configuration words MSB-first into a configuration chain and gates its shift enable.
// Defining CCFF_LOADER_CRC_EN appends a CRC-8 check word after the payload.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 36,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IdxW = $clog2(WORD_W);

`ifdef CCFF_LOADER_CRC_EN
  localparam ccff_ld_state_t FinalSt = StCrcWait;
`else
  localparam ccff_ld_state_t FinalSt = StDone;
`endif

  ccff_ld_state_t    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              head_q, head_d;
  logic              sen_q, sen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, last_bit, word_end;

`ifdef CCFF_LOADER_CRC_EN
  logic       err_q, err_d;
  logic       crc_clr;
  logic [7:0] crc;

  assign cfg_ready = (state_q == StLoad) || (state_q == StCrcWait);

  ccff_crc8 u_crc (
    .clk_i (prog_clk),
    .rst_i (prog_reset),
    .clr_i (crc_clr),
    .en_i  (sen_q),
    .bit_i (head_q),
    .crc_o (crc)
  );
`else
  assign cfg_ready = (state_q == StLoad);
`endif

  assign accept   = cfg_valid & cfg_ready;
  // The final word ends early when the chain fills before WORD_W bits are out.
  assign last_bit = (cnt_q == CntW'(CHAIN_LEN - 1));
  assign word_end = last_bit || (idx_q == IdxW'(WORD_W - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    head_d  = 1'b0;
    sen_d   = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
    err_d   = err_q;
    crc_clr = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
`ifdef CCFF_LOADER_CRC_EN
          err_d   = 1'b0;
          crc_clr = 1'b1;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
          state_d = StShift;
          head_d  = cfg_data[WORD_W-1];
          sen_d   = 1'b1;
          sreg_d  = {cfg_data[WORD_W-2:0], 1'b0};
          idx_d   = '0;
        end
      end
      StShift: begin
        cnt_d = cnt_q + CntW'(1);
        if (word_end) begin
          state_d = last_bit ? FinalSt : StLoad;
        end else begin
          head_d = sreg_q[WORD_W-1];
          sen_d  = 1'b1;
          sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
          idx_d  = idx_q + IdxW'(1);
        end
      end
`ifdef CCFF_LOADER_CRC_EN
      StCrcWait: begin
        if (accept) begin
          err_d   = (cfg_data[7:0] != crc);
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      head_q  <= 1'b0;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      head_q  <= head_d;
      sen_q   <= sen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CCFF_LOADER_CRC_EN
      err_q   <= err_d;
`endif
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = sen_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef CCFF_LOADER_CRC_EN
  assign error         = err_q;
`else
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: chain lengths 36, 8 and 1 with WORD_W=8.
// Follows CCFF_LOADER_CRC_EN for the extra CRC word and done latency.
module tb_ccff_loader;

  localparam int NDUT = 3;
  localparam int unsigned LEN [NDUT] = '{36, 8, 1};
  localparam logic [63:0] GOLD = 64'hA53CFF009;
`ifdef CCFF_LOADER_CRC_EN
  localparam int CrcExtra = 1;
`else
  localparam int CrcExtra = 0;
`endif

  typedef struct {
    logic [63:0] chain;
    int          shifts;
    int          done_cyc;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a [NDUT];
  logic       valid_a [NDUT];
  logic [7:0] data_a  [NDUT];
  logic       ready_a [NDUT];
  logic       head_a  [NDUT];
  logic       sen_a   [NDUT];
  logic       busy_a  [NDUT];
  logic       done_a  [NDUT];
  logic       err_a   [NDUT];

  exp_t        exp_q [NDUT][$];
  logic [63:0] mchain [NDUT];
  int          mshift [NDUT];
  logic [7:0]  payload [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h9F};
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ccff_loader #(.CHAIN_LEN(36), .WORD_W(8)) u_l36 (
    .prog_clk(clk), .prog_reset(rst), .start(start_a[0]), .cfg_data(data_a[0]),
    .cfg_valid(valid_a[0]), .cfg_ready(ready_a[0]), .ccff_head(head_a[0]),
    .ccff_shift_en(sen_a[0]), .busy(busy_a[0]), .done(done_a[0]), .error(err_a[0])
  );
  ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_l8 (
    .prog_clk(clk), .prog_reset(rst), .start(start_a[1]), .cfg_data(data_a[1]),
    .cfg_valid(valid_a[1]), .cfg_ready(ready_a[1]), .ccff_head(head_a[1]),
    .ccff_shift_en(sen_a[1]), .busy(busy_a[1]), .done(done_a[1]), .error(err_a[1])
  );
  ccff_loader #(.CHAIN_LEN(1), .WORD_W(8)) u_l1 (
    .prog_clk(clk), .prog_reset(rst), .start(start_a[2]), .cfg_data(data_a[2]),
    .cfg_valid(valid_a[2]), .cfg_ready(ready_a[2]), .ccff_head(head_a[2]),
    .ccff_shift_en(sen_a[2]), .busy(busy_a[2]), .done(done_a[2]), .error(err_a[2])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

`ifdef CCFF_LOADER_CRC_EN
  function automatic logic [7:0] crc_of(input logic [63:0] bits, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = n - 1; k >= 0; k--) begin
      fb = c[7] ^ bits[k];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  // Monitor: models each chain and checks every done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        mchain[i] = '0;
        mshift[i] = 0;
      end else begin
        if (sen_a[i]) begin
          mchain[i] = ((mchain[i] << 1) | 64'(head_a[i])) & ((64'd1 << LEN[i]) - 64'd1);
          mshift[i]++;
        end
        if (done_a[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_done[%0d]", i), 64'd1, 64'd0);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("chain[%0d]", i), mchain[i], e.chain);
            check($sformatf("shift_count[%0d]", i), 64'(mshift[i]), 64'(e.shifts));
            check($sformatf("done_cycle[%0d]", i), 64'(cyc), 64'(e.done_cyc));
            check($sformatf("error[%0d]", i), 64'(err_a[i]), 64'(e.err));
          end
          mchain[i] = '0;
          mshift[i] = 0;
        end
      end
    end
  end

  function automatic logic [5:0] outs0();
    return {ready_a[0], head_a[0], sen_a[0], busy_a[0], done_a[0], err_a[0]};
  endfunction

  task automatic start_load(output int t0);
    @(posedge clk); #1;
    start_a[0] = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    check("busy_after_start", 64'(busy_a[0]), 64'd1);
    check("ready_in_load", 64'(ready_a[0]), 64'd1);
    check("error_cleared_by_start", 64'(err_a[0]), 64'd0);
  endtask

  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    data_a[0]  = w;
    valid_a[0] = 1'b1;
    @(negedge clk);
    while (!ready_a[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_a[0]) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
      check("done_timeout", 64'd1, 64'd0);
      for (int i = 0; i < NDUT; i++) exp_q[i].delete();
    end
  endtask

  // gap: index of the word preceded by five LOAD cycles with cfg_valid low (-1: none).
  task automatic do_load(input int gap, input bit poke, input bit bad_crc);
    int   t0;
    int   n;
    exp_t e;
    start_load(t0);
    for (int k = 0; k < 5; k++) begin
      if (k == gap) begin
        valid_a[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ready_a[0] && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("gap_shift_en", 64'(sen_a[0]), 64'd0);
        repeat (4) begin
          @(negedge clk);
          check("gap_shift_en", 64'(sen_a[0]), 64'd0);
        end
        @(posedge clk); #1;
      end
      send(payload[k]);
      if (poke && k == 0) begin
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
      end
    end
    e.chain    = GOLD;
    e.shifts   = 36;
    e.done_cyc = t0 + 42 + CrcExtra + ((gap >= 0) ? 5 : 0);
    e.err      = bad_crc;
    exp_q[0].push_back(e);
`ifdef CCFF_LOADER_CRC_EN
    send(crc_of(GOLD, 36) ^ (bad_crc ? 8'h01 : 8'h00));
`endif
    valid_a[0] = 1'b0;
    wait_idle();
  endtask

  initial begin
    int   t0;
    exp_t e;
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      start_a[i] = 1'b0;
      valid_a[i] = 1'b0;
      data_a[i]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'(outs0()), 64'd0);

    do_load(-1, 1'b0, 1'b0);
    do_load(-1, 1'b1, 1'b0);
    do_load(2, 1'b0, 1'b0);

    // Abort during the second word; no done may follow.
    start_load(t0);
    send(payload[0]);
    send(payload[1]);
    valid_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("outputs_after_abort", 64'(outs0()), 64'd0);
    repeat (10) @(negedge clk);
    do_load(-1, 1'b0, 1'b0);

`ifdef CCFF_LOADER_CRC_EN
    do_load(-1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("error_sticky", 64'(err_a[0]), 64'd1);
    do_load(-1, 1'b0, 1'b0);
`endif

    // Short chains, single word 0x80 held valid throughout.
    @(posedge clk); #1;
    start_a[1] = 1'b1;
    start_a[2] = 1'b1;
    t0 = cyc;
    for (int i = 1; i < NDUT; i++) begin
      data_a[i]  = 8'h80;
      valid_a[i] = 1'b1;
    end
    e.chain    = 64'h80;
    e.shifts   = 8;
    e.done_cyc = t0 + 10 + CrcExtra;
`ifdef CCFF_LOADER_CRC_EN
    e.err      = (crc_of(64'h80, 8) != 8'h80);
`else
    e.err      = 1'b0;
`endif
    exp_q[1].push_back(e);
    e.chain    = 64'h1;
    e.shifts   = 1;
    e.done_cyc = t0 + 3 + CrcExtra;
`ifdef CCFF_LOADER_CRC_EN
    e.err      = (crc_of(64'h1, 1) != 8'h80);
`else
    e.err      = 1'b0;
`endif
    exp_q[2].push_back(e);
    @(posedge clk); #1;
    start_a[1] = 1'b0;
    start_a[2] = 1'b0;
    wait_idle();
    valid_a[1] = 1'b0;
    valid_a[2] = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader for the FPGA fabric. It accepts a configuration bitstream as a stream of words over a valid/ready handshake and serializes it onto the `ccff_head` input of a switch-block or tile configuration chain, one bit per enabled `prog_clk` cycle. It sits between the top-level programming interface and the head of each chain, and gates the chain's shift enable so the chain holds its contents outside a load. An optional CRC check validates the stream.

## Interface

Parameters:
- `CHAIN_LEN`, 36: number of configuration flip-flops in the driven chain; must be ≥ 1.
- `WORD_W`, 8: input word width; must be ≥ 2.

Ports:
- `prog_clk` input, 1 bit: programming clock. All state is updated on its rising edge.
- `prog_reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begin a load. Sampled only in IDLE.
- `cfg_data` input, `WORD_W` bits: bitstream word. The MSB is shifted first.
- `cfg_valid` input, 1 bit: `cfg_data` is valid.
- `cfg_ready` output, 1 bit: the loader accepts a word this cycle.
- `ccff_head` output, 1 bit: serial data to the chain head.
- `ccff_shift_en` output, 1 bit: chain shift enable. The chain advances one position on every `prog_clk` edge where this signal is 1.
- `busy` output, 1 bit: a load is in progress.
- `done` output, 1 bit: one-cycle pulse when a load completes.
- `error` output, 1 bit: CRC mismatch on the last load. It is sticky until the next `start` or reset.

## Operation

The FSM has the states IDLE, LOAD, SHIFT, CRC_WAIT and DONE.

- **IDLE.** `busy` is 0. When `start` is 1, the FSM goes to LOAD and clears the bit counter, the CRC register and `error`.
- **LOAD.** `cfg_ready` is 1. On `cfg_valid && cfg_ready`, the shift register captures `cfg_data` and the FSM goes to SHIFT. The number of bits for this word is n = min(`WORD_W`, remaining bits).
- **SHIFT.**
  - Each cycle:
    - `ccff_head` equals the shift-register MSB.
    - `ccff_shift_en` is 1.
    - The shift register moves left by one.
    - The bit counter increments.
  - After n cycles the FSM goes back to LOAD.
  - If the counter has reached `CHAIN_LEN`, the FSM goes to CRC_WAIT instead when the CRC feature is compiled in, or to DONE when it is not.
- **Final word padding.** In the last word, only the top `CHAIN_LEN mod WORD_W` bits are shifted; the remaining low bits are discarded. If that remainder is 0, the whole word is used.
- **Bit order.** The first bit shifted ends up at the tail end of the chain (position `CHAIN_LEN-1`).
- **CRC_WAIT.** Exists only when the CRC feature is compiled in. `cfg_ready` is 1. The accepted word is compared with the computed CRC, `error` is set on mismatch, and the FSM goes to DONE.
- **DONE.** `done` is 1 for exactly one cycle, then the FSM returns to IDLE.
- **Outside SHIFT.** `ccff_shift_en` is 0 and `ccff_head` is 0.
- **`start` while busy.** Ignored.
- **`cfg_valid` low in LOAD.** The FSM waits indefinitely. No shifting occurs and the chain holds its contents.
- **Reset.** When `prog_reset` is 1, including in the middle of a load, the FSM goes to IDLE and all outputs are 0.
  - Partial chain contents are undefined and are not restored.
  - A `done` pulse is never emitted for an aborted load.

## Timing

- **Reset values.** `cfg_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done` and `error` are all 0.
- **Registered outputs.** `busy`, `done`, `error`, `ccff_head` and `ccff_shift_en` are driven directly from registers.
- **`cfg_ready`.** Decoded from the state only. It has no combinational path from `cfg_valid`.
- **`busy`.** 1 from the cycle after `start` through the DONE cycle, inclusive.
- **Per-word cost.** One accept cycle plus n shift cycles.
- **Example latency.** With `CHAIN_LEN`=36, `WORD_W`=8 and `cfg_valid` always 1, with `start` at cycle 0:
  - LOAD in cycles 1, 10, 19, 28 and 37.
  - Shifting in cycles 2–9, 11–18, 20–27, 29–36 and 38–41.
  - Without CRC, `done` is 1 in cycle 42.
  - With CRC, the CRC word is accepted in cycle 42 and `done` is 1 in cycle 43.
- **Shift-enable count.** Exactly `CHAIN_LEN` cycles with `ccff_shift_en`=1 per completed load.

## Configuration

- Macro: `CCFF_LOADER_CRC_EN`.
- **Defined:**
  - CRC-8 with polynomial 0x07 and initial value 0x00, updated once per shifted bit with `ccff_head` as the input bit.
  - The state CRC_WAIT exists, and one extra word is consumed after the payload. Only its low 8 bits are compared; this requires `WORD_W` ≥ 8.
- **Undefined:** there is no CRC logic, CRC_WAIT is absent and `error` is tied to 0.

## Structure

- **Package `ccff_loader_pkg`:**
  - The state enum `ccff_ld_state_t`.
  - `CCFF_CRC_POLY` = 8'h07.
  - `CCFF_CRC_INIT` = 8'h00.
  - The function `ccff_crc8_step(crc, bit)`.
- **Sub-module:** `ccff_crc8`, a serial CRC register with clear and enable inputs. It is instantiated only under the macro.
- **Counter width:** `$clog2(CHAIN_LEN+1)`.

## Test plan

Unless stated otherwise, all scenarios use `CHAIN_LEN`=36 and `WORD_W`=8.

- **Basic load.** Start, then send words 0xA5, 0x3C, 0xFF, 0x00, 0x9F with `cfg_valid` always 1.
  - A model 36-bit shift chain holds 0xA53CFF009.
  - There are 36 `ccff_shift_en` pulses.
  - `done` is 1 in cycle 42.
- **Backpressure.** Deassert `cfg_valid` for 5 cycles before word 3.
  - `ccff_shift_en` stays 0 during the gap.
  - The final chain contents are the same as in the basic load.
  - `done` is 5 cycles later.
- **Reset mid-load.** Assert `prog_reset` during word 2.
  - The next cycle shows IDLE with all outputs 0 and no `done` pulse.
  - A subsequent full load completes correctly.
- **`start` while busy.** Pulse `start` during SHIFT.
  - There is no effect.
  - There is exactly one `done` pulse.
- **CRC (macro defined).** Send the basic-load payload.
  - With the correct CRC word, `error` is 0.
  - With the CRC word XOR 0x01, `error` is 1 at `done` and stays 1 until the next `start`.
- **Edge parameters.** `CHAIN_LEN`=8 and `CHAIN_LEN`=1, each with the single word 0x80.
  - `CHAIN_LEN`=8 gives exactly 8 shifts.
  - `CHAIN_LEN`=1 gives exactly 1 shift, and the chain holds 1.
